uart_tx_frame_ctrl: RTL

Transmit-side frame sequencer for the UART Tx path. It accepts a parallel byte on a Send request and latches the frame configuration. It then steps through the start, data, optional parity and stop bits on each baud tick, driving the serial line. It sits between the host-facing Tx interface and the baud generator, and owns the parity decision for the frame.

---
 rtl/uart_tx_frame_ctrl_if.sv | 33 +++
 rtl/uart_tx_frame_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ctrl_if.sv
// uart_tx_frame_ctrl_if
// Host-facing Tx bundle for the UART transmit frame sequencer.
//   Send        - transmit request (host -> sequencer)
//   DataIn      - byte to send, LSB first
//   ParityType  - 00 none, 01 odd, 10 even, 11 none
//   DataLength  - 00=5, 01=6, 10=7, 11=8 data bits
//   StopBits    - 0 one stop bit, 1 two stop bits
//   DataOut     - serial line, idle high (sequencer -> host/pin)
//   ActiveFlag  - frame in progress
//   DoneFlag    - one-cycle pulse at frame completion
// The master modport is the host side, the slave modport is the sequencer.
interface uart_tx_frame_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              Send;
  logic [DATA_W-1:0] DataIn;
  logic [1:0]        ParityType;
  logic [1:0]        DataLength;
  logic              StopBits;
  logic              DataOut;
  logic              ActiveFlag;
  logic              DoneFlag;

  modport master (
    output Send, DataIn, ParityType, DataLength, StopBits,
    input  DataOut, ActiveFlag, DoneFlag
  );

  modport slave (
    input  Send, DataIn, ParityType, DataLength, StopBits,
    output DataOut, ActiveFlag, DoneFlag
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
// Transmit-side UART frame sequencer. Accepts a byte on Send while idle,
// freezes the frame configuration, then walks start, data, optional parity
// and stop bits, advancing one bit per BaudTick.
// Ports:
//   Clock     - system clock, rising edge
//   ResetN    - asynchronous active-low reset
//   BaudTick  - one-cycle pulse per bit period from the baud generator
//   tx        - host Tx bundle (slave modport), see uart_tx_frame_ctrl_if
// All outputs are registered.
module uart_tx_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 BaudTick,
  uart_tx_frame_ctrl_if.slave  tx
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        par_type_q, par_type_d;
  logic [1:0]        len_q, len_d;
  logic              stop_q, stop_d;
  logic              dout_q, dout_d;
  logic              active_q, active_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  last_idx;
  logic              parity_en;
  logic              par_xor;

  // Frame bookkeeping derived from the latched configuration. DataLength
  // encodes 5..8 bits, so the last data index is the code plus four.
  always_comb begin
    last_idx  = CNT_W'(len_q) + CNT_W'(4);
    parity_en = (par_type_q == 2'b01) || (par_type_q == 2'b10);
    par_xor   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(len_q) + 5) par_xor = par_xor ^ data_q[i];
    end
  end

  // Next-state logic; outputs are computed from the next state so that the
  // registered line value changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    par_type_d = par_type_q;
    len_d      = len_q;
    stop_d     = stop_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx.Send) begin
          data_d     = tx.DataIn;
          par_type_d = tx.ParityType;
          len_d      = tx.DataLength;
          stop_d     = tx.StopBits;
          state_d    = ARM;
        end
      end
      ARM: begin
        // Waiting for a tick aligns the start bit to a full bit period.
        if (BaudTick) state_d = START;
      end
      START: begin
        if (BaudTick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (BaudTick) begin
          if (idx_q == last_idx) begin
            state_d = parity_en ? PARITY : STOP1;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (BaudTick) state_d = STOP1;
      end
      STOP1: begin
        if (BaudTick) begin
          if (stop_q) begin
            state_d = STOP2;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      STOP2: begin
        if (BaudTick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);

    case (state_d)
      START:   dout_d = 1'b0;
      DATA:    dout_d = data_q[idx_d];
      PARITY:  dout_d = (par_type_q == 2'b10) ? par_xor : ~par_xor;
      default: dout_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      par_type_q <= '0;
      len_q      <= '0;
      stop_q     <= 1'b0;
      dout_q     <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      par_type_q <= par_type_d;
      len_q      <= len_d;
      stop_q     <= stop_d;
      dout_q     <= dout_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign tx.DataOut    = dout_q;
  assign tx.ActiveFlag = active_q;
  assign tx.DoneFlag   = done_q;

endmodule
